// File: rtl/dma_axi32_slv_pkg.sv
// rtl/dma_axi32_slv_pkg.sv - shared constants, FSM states and address helper for the AXI3 slave memory
package dma_axi32_slv_pkg;

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;

    typedef enum logic [1:0] {W_IDLE, W_DATA, W_RESP} w_state_t;
    typedef enum logic [1:0] {R_IDLE, R_WAIT, R_DATA} r_state_t;

    // INCR bursts only: each beat advances by the transfer size in bytes
    function automatic logic [31:0] beat_addr_next(input logic [31:0] addr, input logic [2:0] size);
        return addr + (32'd1 << size);
    endfunction

endpackage

// File: rtl/dma_axi32_slv_ram.sv
// rtl/dma_axi32_slv_ram.sv - word array with one byte-enable write port and one registered read port
module dma_axi32_slv_ram #(
    parameter int MEM_AW = 10
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              wr_en,
    input  logic [MEM_AW-1:0] wr_addr,
    input  logic [31:0]       wr_data,
    input  logic [3:0]        wr_strb,
    input  logic              rd_en,
    input  logic [MEM_AW-1:0] rd_addr,
    output logic [31:0]       rd_data
);

    logic [31:0] mem [0:(2**MEM_AW)-1];

    always_ff @(posedge clk) begin
        if (wr_en) begin
            for (int b = 0; b < 4; b++) begin
                if (wr_strb[b]) mem[wr_addr][8*b +: 8] <= wr_data[8*b +: 8];
            end
        end
    end

    // a read in the same cycle as a write to that word sees the old contents
    always_ff @(posedge clk or posedge reset) begin
        if (reset)      rd_data <= '0;
        else if (rd_en) rd_data <= mem[rd_addr];
    end

endmodule

// File: rtl/dma_axi32_slave_mem.sv
// rtl/dma_axi32_slave_mem.sv - AXI3 32-bit slave memory with independent write and read engines
module dma_axi32_slave_mem
    import dma_axi32_slv_pkg::*;
#(
    parameter int ID_BITS   = 4,
    parameter int LEN_BITS  = 4,
    parameter int SIZE_BITS = 2,
    parameter int MEM_AW    = 10,
    parameter int RD_LAT    = 2
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 stall,
    input  logic [ID_BITS-1:0]   AWID0,
    input  logic [31:0]          AWADDR0,
    input  logic [LEN_BITS-1:0]  AWLEN0,
    input  logic [SIZE_BITS-1:0] AWSIZE0,
    input  logic                 AWVALID0,
    output logic                 AWREADY0,
    input  logic [ID_BITS-1:0]   WID0,
    input  logic [31:0]          WDATA0,
    input  logic [3:0]           WSTRB0,
    input  logic                 WLAST0,
    input  logic                 WVALID0,
    output logic                 WREADY0,
    output logic [ID_BITS-1:0]   BID0,
    output logic [1:0]           BRESP0,
    output logic                 BVALID0,
    input  logic                 BREADY0,
    input  logic [ID_BITS-1:0]   ARID0,
    input  logic [31:0]          ARADDR0,
    input  logic [LEN_BITS-1:0]  ARLEN0,
    input  logic [SIZE_BITS-1:0] ARSIZE0,
    input  logic                 ARVALID0,
    output logic                 ARREADY0,
    output logic [ID_BITS-1:0]   RID0,
    output logic [31:0]          RDATA0,
    output logic [1:0]           RRESP0,
    output logic                 RLAST0,
    output logic                 RVALID0,
    input  logic                 RREADY0
);

    localparam int LAT_W = (RD_LAT > 2) ? $clog2(RD_LAT) : 1;

    function automatic logic addr_oor(input logic [31:0] a);
        return (a >> (MEM_AW + 2)) != 32'd0;
    endfunction

    w_state_t             w_state, w_state_nx;
    logic [ID_BITS-1:0]   w_id;
    logic [31:0]          w_addr;
    logic [LEN_BITS-1:0]  w_len, w_beat;
    logic [SIZE_BITS-1:0] w_size;
    logic                 w_err;
    logic                 aw_hs, w_hs, w_beat_err, w_last_beat;

    r_state_t             r_state, r_state_nx;
    logic [ID_BITS-1:0]   r_id;
    logic [31:0]          r_addr, ld_addr;
    logic [LEN_BITS-1:0]  r_len, r_beat, ld_len, ld_beat;
    logic [SIZE_BITS-1:0] r_size;
    logic [LAT_W-1:0]     lat_cnt;
    logic                 r_oor, r_load, ar_hs;
    logic [31:0]          ram_rdata;

    logic                 unused_wid;
    assign unused_wid = ^WID0;

    assign aw_hs       = AWVALID0 && AWREADY0;
    assign w_hs        = WVALID0 && WREADY0;
    assign ar_hs       = ARVALID0 && ARREADY0;
    assign w_last_beat = (w_beat == w_len);
    assign w_beat_err  = addr_oor(w_addr) || (WLAST0 != w_last_beat);

    always_comb begin
        w_state_nx = w_state;
        case (w_state)
            W_IDLE:  if (aw_hs) w_state_nx = W_DATA;
            W_DATA:  if (w_hs && w_last_beat) w_state_nx = W_RESP;
            W_RESP:  if (BREADY0) w_state_nx = W_IDLE;
            default: w_state_nx = W_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            w_state  <= W_IDLE;
            w_id     <= '0;
            w_addr   <= '0;
            w_len    <= '0;
            w_size   <= '0;
            w_beat   <= '0;
            w_err    <= 1'b0;
            AWREADY0 <= 1'b0;
            WREADY0  <= 1'b0;
            BVALID0  <= 1'b0;
            BRESP0   <= RESP_OKAY;
        end else begin
            w_state  <= w_state_nx;
            AWREADY0 <= (w_state_nx == W_IDLE) && !stall;
            WREADY0  <= (w_state_nx == W_DATA) && !stall;
            case (w_state)
                W_IDLE: if (aw_hs) begin
                    w_id   <= AWID0;
                    w_addr <= AWADDR0;
                    w_len  <= AWLEN0;
                    w_size <= AWSIZE0;
                    w_beat <= '0;
                    w_err  <= 1'b0;
                end
                // the burst always ends at beat len; a WLAST mismatch only poisons the response
                W_DATA: if (w_hs) begin
                    if (w_last_beat) begin
                        BVALID0 <= 1'b1;
                        BRESP0  <= (w_err || w_beat_err) ? RESP_SLVERR : RESP_OKAY;
                    end else begin
                        w_beat <= w_beat + 1'b1;
                        w_addr <= beat_addr_next(w_addr, 3'(w_size));
                        w_err  <= w_err || w_beat_err;
                    end
                end
                W_RESP: if (BREADY0) BVALID0 <= 1'b0;
                default: ;
            endcase
        end
    end

    assign BID0 = w_id;

    // r_load marks the edge at which a beat is fetched and presented on R
    always_comb begin
        r_state_nx = r_state;
        r_load     = 1'b0;
        ld_addr    = r_addr;
        ld_len     = r_len;
        ld_beat    = '0;
        case (r_state)
            R_IDLE: if (ar_hs) begin
                ld_addr = ARADDR0;
                ld_len  = ARLEN0;
                if (RD_LAT <= 1) begin
                    r_load     = 1'b1;
                    r_state_nx = R_DATA;
                end else begin
                    r_state_nx = R_WAIT;
                end
            end
            R_WAIT: if (lat_cnt == LAT_W'(RD_LAT - 2)) begin
                r_load     = 1'b1;
                r_state_nx = R_DATA;
            end
            R_DATA: if (RREADY0) begin
                if (RLAST0) begin
                    r_state_nx = R_IDLE;
                end else begin
                    r_load  = 1'b1;
                    ld_addr = beat_addr_next(r_addr, 3'(r_size));
                    ld_beat = r_beat + 1'b1;
                end
            end
            default: r_state_nx = R_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state  <= R_IDLE;
            r_id     <= '0;
            r_addr   <= '0;
            r_len    <= '0;
            r_size   <= '0;
            r_beat   <= '0;
            lat_cnt  <= '0;
            r_oor    <= 1'b0;
            ARREADY0 <= 1'b0;
            RVALID0  <= 1'b0;
            RLAST0   <= 1'b0;
            RRESP0   <= RESP_OKAY;
        end else begin
            r_state  <= r_state_nx;
            ARREADY0 <= (r_state_nx == R_IDLE) && !stall;
            if (r_state == R_IDLE && ar_hs) begin
                r_id    <= ARID0;
                r_addr  <= ARADDR0;
                r_len   <= ARLEN0;
                r_size  <= ARSIZE0;
                lat_cnt <= '0;
            end else if (r_state == R_WAIT) begin
                lat_cnt <= lat_cnt + 1'b1;
            end
            if (r_load) begin
                RVALID0 <= 1'b1;
                r_addr  <= ld_addr;
                r_beat  <= ld_beat;
                RLAST0  <= (ld_beat == ld_len);
                RRESP0  <= addr_oor(ld_addr) ? RESP_SLVERR : RESP_OKAY;
                r_oor   <= addr_oor(ld_addr);
            end else if (r_state == R_DATA && RREADY0) begin
                RVALID0 <= 1'b0;
                RLAST0  <= 1'b0;
                RRESP0  <= RESP_OKAY;
                r_oor   <= 1'b0;
            end
        end
    end

    assign RID0   = r_id;
    assign RDATA0 = r_oor ? 32'd0 : ram_rdata;

    dma_axi32_slv_ram #(.MEM_AW(MEM_AW)) u_ram (
        .clk     (clk),
        .reset   (reset),
        .wr_en   (w_state == W_DATA && w_hs && !addr_oor(w_addr)),
        .wr_addr (w_addr[MEM_AW+1:2]),
        .wr_data (WDATA0),
        .wr_strb (WSTRB0),
        .rd_en   (r_load),
        .rd_addr (ld_addr[MEM_AW+1:2]),
        .rd_data (ram_rdata)
    );

endmodule

// File: doc/dma_axi32_slave_mem.md
Name: dma_axi32_slave_mem

Overview:
AXI3 32-bit slave memory that sits directly downstream of the dma_axi32 master port (AW/W/B/AR/R channel 0) in the harness.
- Stores write bursts and returns read bursts, so DMA transfers complete end to end.
- Error responses and backpressure are controllable to exercise the DMA's error and stall paths.
- Independent write and read engines; one outstanding transaction per direction.

Parameters:
- ID_BITS, 4: AXI ID width; matches the DMA ID_BITS define.
- LEN_BITS, 4: AXI3 burst length field width.
- SIZE_BITS, 2: AXI size field width.
- MEM_AW, 10: word-address width; memory is 2**MEM_AW 32-bit words starting at byte address 0.
- RD_LAT, 2: cycles from AR handshake to first RVALID (minimum 1).

Ports:
- clk  in  1  clock
- reset  in  1  asynchronous, active-high reset
- stall  in  1  when high, forces AWREADY, WREADY and ARREADY low
- AWID0  in  ID_BITS  write ID
- AWADDR0  in  32  write byte address
- AWLEN0  in  LEN_BITS  beats-1
- AWSIZE0  in  SIZE_BITS  bytes per beat = 1<<size
- AWVALID0  in  1; AWREADY0  out  1
- WID0  in  ID_BITS; WDATA0  in  32; WSTRB0  in  4; WLAST0  in  1
- WVALID0  in  1; WREADY0  out  1
- BID0  out  ID_BITS; BRESP0  out  2; BVALID0  out  1; BREADY0  in  1
- ARID0  in  ID_BITS; ARADDR0  in  32; ARLEN0  in  LEN_BITS; ARSIZE0  in  SIZE_BITS
- ARVALID0  in  1; ARREADY0  out  1
- RID0  out  ID_BITS; RDATA0  out  32; RRESP0  out  2; RLAST0  out  1
- RVALID0  out  1; RREADY0  in  1

Behaviour:
- Clock and reset: single clock clk; reset is asynchronous, active-high.
- Reset values: all outputs 0. Both FSMs go to IDLE and all beat and latency counters clear. Memory contents are not reset.
- Ready outputs are registered. AWREADY/ARREADY are 1 in IDLE when stall=0, with the first assertion one cycle after reset deasserts.
- Bursts are INCR only. Beat address = start + n*(1<<size). Word index = addr[MEM_AW+1:2].
- A beat is out of range if any byte address bit at or above MEM_AW+2 is set. An out-of-range beat makes the response SLVERR (2'b10).
- Write FSM, IDLE -> WDATA -> WRESP -> IDLE:
  - IDLE: on AW handshake, latch ID/addr/len/size and clear the beat counter.
  - WDATA: WREADY=!stall. Each W handshake writes the bytes enabled by WSTRB (in range only) and increments the counter.
  - WLAST must coincide with beat == len. On mismatch (early WLAST, or WLAST missing at beat len) the response is SLVERR and the burst ends at beat len; extra W beats are not accepted.
  - WID is not checked.
  - WRESP: BVALID=1, BID=latched ID, BRESP=OKAY(00) or SLVERR. Held stable until BREADY; go to IDLE on the cycle after the B handshake.
- Read FSM, IDLE -> RWAIT -> RDATA -> IDLE:
  - IDLE: latch AR fields on handshake.
  - RWAIT: count RD_LAT-1 cycles, so the first RVALID appears RD_LAT cycles after the AR handshake.
  - RDATA: RVALID=1 with RDATA = full word (0 if out of range), RRESP per beat, RID = latched ID, RLAST=1 on beat == len.
  - While RREADY=0, all R outputs hold stable. On a handshake the next beat is presented in the following cycle (back-to-back at 1 beat/cycle when RREADY=1). Go to IDLE after the RLAST handshake.
- Concurrent read and write to the same word: a W write commits at the end of its handshake cycle. An R beat registered in the same cycle returns old data; later beats return new data.
- Simultaneous AW and AR handshakes are both accepted.
- stall affects only ready outputs. It never deasserts a VALID that has already been driven.
- Reset mid-burst aborts both FSMs immediately. Partial writes already committed remain in memory.

Decomposition:
- Package dma_axi32_slv_pkg: RESP_OKAY/RESP_SLVERR constants, write FSM enum (IDLE/WDATA/WRESP), read FSM enum (IDLE/RWAIT/RDATA), beat-address increment function.
- Sub-module dma_axi32_slv_ram: 2**MEM_AW x 32 array with one byte-enable write port and one synchronous read port.

Test Plan:
- Write AWADDR=0x100, LEN=3, SIZE=2, data 0x11111111..0x44444444, WSTRB=F -> one B with BRESP=00, BID=AWID, one cycle after WLAST handshake.
- Read back ARADDR=0x100, LEN=3 with RREADY=1 -> first RVALID 2 cycles after AR; 4 back-to-back beats matching the written data; RLAST only on beat 3; RID=ARID.
- Write 0xAABBCCDD with WSTRB=0101 to a word holding 0 -> readback 0x00BB00DD.
- AWADDR=0x1000 (out of range for MEM_AW=10) -> BRESP=10, memory unchanged. Read of the same address -> RDATA=0, RRESP=10 on every beat.
- Toggle RREADY and stall pseudo-randomly over a 16-beat read -> RID/RDATA/RLAST stable while RVALID&!RREADY; no beat lost or duplicated.
- WLAST asserted on beat 1 of a LEN=3 burst -> BRESP=10, burst completes after 4 beats. Separately, assert reset during beat 2 -> all VALID/READY outputs 0 in the same cycle and both FSMs in IDLE.
